systolic_array_ctrl: RTL

SYSTOLIC_ARRAY_CTRL -- requirements
Module: systolic_array_ctrl

---
 rtl/systolic_array_ctrl.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/systolic_array_ctrl.sv
// Sequencer for a weight-stationary systolic array: clears PE weights, shifts weight rows
// in bottom-first, streams activation vectors, drains the pipeline and pulses done.
module systolic_array_ctrl #(
  parameter int ROWS  = 4,
  parameter int COLS  = 4,
  parameter int CNT_W = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      abort,
  input  logic [CNT_W-1:0]          cfg_num_vec,
  input  logic                      stall,
  output logic                      PE_clear_weight,
  output logic                      PE_weight_partial_sel,
  output logic                      PE_mac_enable,
  output logic                      wet_rd_en,
  output logic [$clog2(ROWS)-1:0]   wet_rd_addr,
  output logic                      act_rd_en,
  output logic [CNT_W-1:0]          act_rd_addr,
  output logic                      busy,
  output logic                      done,
  output logic [2:0]                dbg_state
);

  localparam int AW = $clog2(ROWS);
  localparam int DW = $clog2(ROWS + COLS);
  localparam logic [AW-1:0] LAST_ROW  = AW'(ROWS - 1);
  localparam logic [DW-1:0] DRAIN_LEN = DW'(ROWS + COLS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    LOAD_W = 3'd2,
    SETTLE = 3'd3,
    MAC    = 3'd4,
    DRAIN  = 3'd5,
    DONE   = 3'd6
  } state_t;

  state_t           r_state, w_next_state;
  logic [CNT_W-1:0] r_num_vec, w_num_vec;
  logic [CNT_W-1:0] r_mac_cnt, w_mac_cnt;
  logic [DW-1:0]    r_drn_cnt, w_drn_cnt;
  logic [AW-1:0]    r_wet_cnt, w_wet_cnt;

  logic             w_clear, w_sel, w_mac_en, w_wet_en, w_act_en, w_busy, w_done;
  logic [AW-1:0]    w_wet_addr;
  logic [CNT_W-1:0] w_act_addr;

  // Outputs are decoded from the state being entered, so each registered strobe
  // lines up with the cycle that state occupies; stall is sampled at that same edge.
  always_comb begin
    w_next_state = r_state;
    w_num_vec    = r_num_vec;
    w_mac_cnt    = r_mac_cnt;
    w_drn_cnt    = r_drn_cnt;
    w_wet_cnt    = r_wet_cnt;
    w_clear      = 1'b0;
    w_sel        = 1'b0;
    w_mac_en     = 1'b0;
    w_wet_en     = 1'b0;
    w_act_en     = 1'b0;
    w_wet_addr   = '0;
    w_act_addr   = '0;

    case (r_state)
      IDLE: begin
        if (start && !abort) begin
          w_num_vec    = cfg_num_vec;
          w_next_state = (cfg_num_vec == '0) ? DONE : CLEAR;
        end
      end
      CLEAR: begin
        w_next_state = LOAD_W;
        w_wet_cnt    = LAST_ROW;
      end
      LOAD_W: begin
        if (r_wet_cnt == '0) w_next_state = SETTLE;
        else                 w_wet_cnt    = r_wet_cnt - 1'b1;
      end
      SETTLE: begin
        w_next_state = MAC;
        w_mac_cnt    = '0;
      end
      MAC: begin
        if (r_mac_cnt == r_num_vec) begin
          w_next_state = DRAIN;
          w_drn_cnt    = '0;
        end
      end
      DRAIN: begin
        if (r_drn_cnt == DRAIN_LEN) w_next_state = DONE;
      end
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase

    if (abort && r_state != IDLE) w_next_state = IDLE;

    case (w_next_state)
      CLEAR: w_clear = 1'b1;
      LOAD_W: begin
        w_sel      = 1'b1;
        w_wet_en   = 1'b1;
        w_wet_addr = w_wet_cnt;
      end
      MAC: begin
        w_act_addr = w_mac_cnt;
        if (!stall) begin
          w_mac_en  = 1'b1;
          w_act_en  = 1'b1;
          w_mac_cnt = w_mac_cnt + 1'b1;
        end
      end
      DRAIN: begin
        if (!stall) begin
          w_mac_en  = 1'b1;
          w_drn_cnt = w_drn_cnt + 1'b1;
        end
      end
      default: ;
    endcase

    w_busy = (w_next_state != IDLE);
    w_done = (w_next_state == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state               <= IDLE;
      r_num_vec             <= '0;
      r_mac_cnt             <= '0;
      r_drn_cnt             <= '0;
      r_wet_cnt             <= '0;
      PE_clear_weight       <= 1'b0;
      PE_weight_partial_sel <= 1'b0;
      PE_mac_enable         <= 1'b0;
      wet_rd_en             <= 1'b0;
      wet_rd_addr           <= '0;
      act_rd_en             <= 1'b0;
      act_rd_addr           <= '0;
      busy                  <= 1'b0;
      done                  <= 1'b0;
    end else begin
      r_state               <= w_next_state;
      r_num_vec             <= w_num_vec;
      r_mac_cnt             <= w_mac_cnt;
      r_drn_cnt             <= w_drn_cnt;
      r_wet_cnt             <= w_wet_cnt;
      PE_clear_weight       <= w_clear;
      PE_weight_partial_sel <= w_sel;
      PE_mac_enable         <= w_mac_en;
      wet_rd_en             <= w_wet_en;
      wet_rd_addr           <= w_wet_addr;
      act_rd_en             <= w_act_en;
      act_rd_addr           <= w_act_addr;
      busy                  <= w_busy;
      done                  <= w_done;
    end
  end

  assign dbg_state = r_state;

endmodule
